// File: rtl/rolhas_pkg.sv
// ============================================================================
// Module   : rolhas_pkg
// Purpose  : Shared constants for the cork magazine stock controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rolhas_pkg;

   localparam int c_count_w        = 7;
   localparam int c_capacity_def   = 99;
   localparam int c_refill_qty_def = 15;
   localparam int c_threshold_def  = 5;

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_refill = 2'd1;
   localparam logic [1:0] c_st_fault  = 2'd2;

endpackage : rolhas_pkg

`default_nettype wire

// File: rtl/conversor_bcd_rolhas.sv
// ============================================================================
// Module   : conversor_bcd_rolhas
// Purpose  : Combinational 7-bit binary to two-digit BCD (valid for 0..99).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conversor_bcd_rolhas
   import rolhas_pkg::*;
(
   input  logic [c_count_w-1:0] bin,
   output logic [3:0]           tens,
   output logic [3:0]           units
);

   assign tens  = 4'(bin / 7'd10);
   assign units = 4'(bin % 7'd10);

endmodule : conversor_bcd_rolhas

`default_nettype wire

// File: rtl/controlador_estoque_rolhas.sv
// ============================================================================
// Module   : controlador_estoque_rolhas
// Purpose  : Cork stock counter with per-bottle dispensing, refill req/ack
//            handshake and BCD display digits. ROLHAS_TIMEOUT_EN enables the
//            refill acknowledge watchdog and the FAULT state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_estoque_rolhas
   import rolhas_pkg::*;
#(
   parameter int CAPACITY    = c_capacity_def,
   parameter int REFILL_QTY  = c_refill_qty_def,
   parameter int THRESHOLD   = c_threshold_def,
   parameter int ACK_TIMEOUT = 255
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bottle_req,
   output logic                 bottle_grant,
   output logic                 refill_req,
   input  logic                 refill_ack,
   input  logic                 fault_clr,
   output logic [c_count_w-1:0] count,
   output logic [3:0]           tens_bcd,
   output logic [3:0]           units_bcd,
   output logic                 empty,
   output logic                 low,
   output logic                 fault
);

   localparam logic [c_count_w-1:0] c_capacity  = c_count_w'(CAPACITY);
   localparam logic [c_count_w-1:0] c_threshold = c_count_w'(THRESHOLD);
   localparam logic [c_count_w:0]   c_capacity_x = {1'b0, c_capacity};
   localparam logic [c_count_w:0]   c_refill_x   = (c_count_w+1)'(REFILL_QTY);
   localparam logic [7:0]           c_ack_timeout = 8'(ACK_TIMEOUT);

   logic [1:0]           r_state;
   logic [c_count_w-1:0] r_count;
   logic                 r_grant;
   logic                 r_req;
   logic                 w_grant;
   logic                 w_ack;
   logic                 w_wd_expired;
   logic [c_count_w:0]   w_sum;
   logic [c_count_w-1:0] w_count_next;

   // Grant and accepted lot are applied together; the sum is one bit wider so
   // that an overfull result can be clipped to capacity.
   assign w_grant      = bottle_req & (r_count != '0) & ~r_grant;
   assign w_ack        = r_req & refill_ack;
   assign w_sum        = {1'b0, r_count} - {{c_count_w{1'b0}}, w_grant}
                         + (w_ack ? c_refill_x : '0);
   assign w_count_next = (w_sum > c_capacity_x) ? c_capacity : w_sum[c_count_w-1:0];

`ifdef ROLHAS_TIMEOUT_EN
   logic       r_fault;
   logic [7:0] r_wd;
   logic [7:0] w_wd_next;

   assign w_wd_next    = r_wd + 8'd1;
   assign w_wd_expired = (w_wd_next == c_ack_timeout);
   assign fault        = r_fault;

   // Held at zero outside REFILL, so every refill starts a fresh window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd <= '0;
      end else if (r_state != c_st_refill) begin
         r_wd <= '0;
      end else begin
         r_wd <= w_wd_next;
      end
   end
`else
   logic w_unused;

   assign w_wd_expired = 1'b0;
   assign fault        = 1'b0;
   assign w_unused     = &{1'b0, fault_clr, c_ack_timeout};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_count <= '0;
         r_grant <= 1'b0;
         r_req   <= 1'b0;
`ifdef ROLHAS_TIMEOUT_EN
         r_fault <= 1'b0;
`endif
      end else begin
         r_count <= w_count_next;
         r_grant <= w_grant;
         case (r_state)
            c_st_idle: begin
               if (r_count <= c_threshold) begin
                  r_state <= c_st_refill;
                  r_req   <= 1'b1;
               end
            end
            c_st_refill: begin
               if (w_ack) begin
                  r_state <= c_st_idle;
                  r_req   <= 1'b0;
               end else if (w_wd_expired) begin
                  r_state <= c_st_fault;
                  r_req   <= 1'b0;
`ifdef ROLHAS_TIMEOUT_EN
                  r_fault <= 1'b1;
`endif
               end
            end
            c_st_fault: begin
`ifdef ROLHAS_TIMEOUT_EN
               if (fault_clr) begin
                  r_state <= c_st_idle;
                  r_fault <= 1'b0;
               end
`else
               r_state <= c_st_idle;
`endif
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign bottle_grant = r_grant;
   assign refill_req   = r_req;
   assign count        = r_count;
   assign empty        = (r_count == '0);
   assign low          = (r_count <= c_threshold);

   conversor_bcd_rolhas u_bcd (
      .bin   (r_count),
      .tens  (tens_bcd),
      .units (units_bcd)
   );

endmodule : controlador_estoque_rolhas

`default_nettype wire

// File: tb/tb_controlador_estoque_rolhas.sv
// ============================================================================
// Module   : tb_controlador_estoque_rolhas
// Purpose  : Self-checking bench: directed vectors, corner sequences and
//            random traffic against a behavioural stock model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controlador_estoque_rolhas;

   localparam int CAP = 99;
   localparam int RQ  = 15;
   localparam int THR = 5;
`ifdef ROLHAS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       br = 1'b0, ack = 1'b0, clr = 1'b0;
   logic       grant, req, empty, low, fault;
   logic [6:0] count;
   logic [3:0] tens, units;

   logic       rst2_n = 1'b0;
   logic       br2 = 1'b0, ack2 = 1'b0, clr2 = 1'b0;
   logic       grant2, req2, empty2, low2, fault2;
   logic [6:0] count2;
   logic [3:0] tens2, units2;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   int m_count, m_wait;
   bit m_grant, m_req, m_fault;

   always #5 clk = ~clk;

   controlador_estoque_rolhas u_dut (
      .clk(clk), .rst_n(rst_n), .bottle_req(br), .bottle_grant(grant),
      .refill_req(req), .refill_ack(ack), .fault_clr(clr), .count(count),
      .tens_bcd(tens), .units_bcd(units), .empty(empty), .low(low), .fault(fault)
   );

   // high threshold so the stock can be pushed to capacity through refills
   controlador_estoque_rolhas #(.THRESHOLD(95)) u_sat (
      .clk(clk), .rst_n(rst2_n), .bottle_req(br2), .bottle_grant(grant2),
      .refill_req(req2), .refill_ack(ack2), .fault_clr(clr2), .count(count2),
      .tens_bcd(tens2), .units_bcd(units2), .empty(empty2), .low(low2), .fault(fault2)
   );

   typedef struct {
      bit br;
      bit ack;
      int c;
      bit g;
      bit r;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_count = 0; m_wait = 0; m_grant = 0; m_req = 0; m_fault = 0;
   endtask

   task automatic m_edge();
      int g, acc, nc;
      g   = (br && m_count > 0 && !m_grant) ? 1 : 0;
      acc = (m_req && ack) ? 1 : 0;
      nc  = m_count - g + acc * RQ;
      if (nc > CAP) nc = CAP;
      if (!m_req && !m_fault) begin
         if (m_count <= THR) begin m_req = 1; m_wait = 0; end
      end else if (m_req) begin
         if (acc == 1) m_req = 0;
         else if (TO_EN) begin
            m_wait++;
            if (m_wait == 255) begin m_req = 0; m_fault = 1; end
         end
      end else if (clr) begin
         m_fault = 0;
      end
      m_count = nc;
      m_grant = (g == 1);
   endtask

   task automatic cmp_model();
      chk("count", int'(count), m_count);
      chk("grant", int'(grant), int'(m_grant));
      chk("refill_req", int'(req), int'(m_req));
      chk("fault", int'(fault), int'(m_fault));
      chk("tens", int'(tens), m_count / 10);
      chk("units", int'(units), m_count % 10);
      chk("empty", int'(empty), int'(m_count == 0));
      chk("low", int'(low), int'(m_count <= THR));
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      #1;
      cmp_model();
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_count"}, int'(count), 0);
      chk({nm, "_grant"}, int'(grant), 0);
      chk({nm, "_req"}, int'(req), 0);
      chk({nm, "_fault"}, int'(fault), 0);
      chk({nm, "_empty"}, int'(empty), 1);
      chk({nm, "_low"}, int'(low), 1);
      chk({nm, "_digits"}, int'({tens, units}), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      // directed table: inputs applied before an edge, outputs expected after
      vt.push_back('{br:0, ack:0, c:0,  g:0, r:1});
      vt.push_back('{br:0, ack:1, c:15, g:0, r:0});
      for (int k = 0; k < 20; k++)
         vt.push_back('{br:1, ack:0, c:14 - k/2, g:(k % 2 == 0), r:(k == 19)});
      vt.push_back('{br:1, ack:0, c:4,  g:1, r:1});
      vt.push_back('{br:0, ack:0, c:4,  g:0, r:1});
      vt.push_back('{br:1, ack:0, c:3,  g:1, r:1});
      vt.push_back('{br:0, ack:0, c:3,  g:0, r:1});
      vt.push_back('{br:1, ack:1, c:17, g:1, r:0});

      m_reset();
      #2;
      chk_reset_vals("reset");
      #6 rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         br = vt[i].br; ack = vt[i].ack;
         step();
         chk($sformatf("vec%0d_count", i), int'(count), vt[i].c);
         chk($sformatf("vec%0d_grant", i), int'(grant), int'(vt[i].g));
         chk($sformatf("vec%0d_req", i), int'(req), int'(vt[i].r));
      end
      br = 0; ack = 0;

      // asynchronous reset mid-cycle while a grant pulse is showing
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_reset");
      m_reset();
      #3 rst_n = 1'b1;

      // empty magazine: requests wait until the lot arrives
      br = 1;
      step();
      chk("starve_req", int'(req), 1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("starve_grant", int'(grant), 0);
      end
      ack = 1;
      step();
      ack = 0;
      chk("starve_ack_count", int'(count), 15);
      chk("starve_ack_grant", int'(grant), 0);
      step();
      chk("starve_after_count", int'(count), 14);
      chk("starve_after_grant", int'(grant), 1);
      br = 0;

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         br  = ($urandom_range(0, 9) < 7);
         ack = ($urandom_range(0, 4) == 0);
         clr = ($urandom_range(0, 19) == 0);
         step();
      end
      br = 0; ack = 0; clr = 0;

      // saturation on the high-threshold instance
      #2 rst2_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk("sat_req", int'(req2), 1);
         ack2 = 1;
         step();
         ack2 = 0;
         chk("sat_count", int'(count2), (15 * i > 99) ? 99 : 15 * i);
      end
      chk("sat_digits", int'({tens2, units2}), 8'h99);
      chk("sat_req_low", int'(req2), 0);
      step();
      chk("sat_idle", int'(req2), 0);

`ifdef ROLHAS_TIMEOUT_EN
      rst_n = 1'b0;
      #1 m_reset();
      #1 rst_n = 1'b1;
      step();
      chk("wd_req", int'(req), 1);
      for (int i = 1; i <= 255; i++) begin
         step();
         if (i == 254) chk("wd_before", int'(fault), 0);
      end
      chk("wd_fault", int'(fault), 1);
      chk("wd_req_drop", int'(req), 0);
      clr = 1;
      step();
      clr = 0;
      chk("wd_clr_fault", int'(fault), 0);
      step();
      chk("wd_rereq", int'(req), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_controlador_estoque_rolhas

`default_nettype wire
